// File: rtl/ssm_tile_sequencer.sv
// rtl/ssm_tile_sequencer.sv - tile scheduler in front of the SSM compute core
//
// Walks every (h_tile, p_tile) pair, presents the matching dt/dA/D/x slices to
// the core, pulses core_start, waits for core_done and scatters y_tile into the
// full-size y_flat buffer.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, abort          run request (IDLE only) / cancel a run in progress
//   order_p               0: p inner loop, 1: h inner loop (latched on start)
//   dt_flat, dA_flat      per-head, per-batch scalars
//   D_flat, x_flat        per-head D, full input x
//   core_start/core_done  handshake with the compute core
//   dt_tile..x_tile       combinational slices for the current tile
//   y_tile                core result for the current tile
//   tile_h_idx/p_idx      current tile indices (also drive the state fetcher)
//   tiles_done            tiles written in the current run
//   y_flat                assembled output buffer
//   busy, done, err       status: non-idle, end-of-run pulse, sticky timeout

module ssm_tile_sequencer #(
    parameter int B      = 1,
    parameter int H      = 24,
    parameter int P      = 64,
    parameter int H_TILE = 12,
    parameter int P_TILE = 32,
    parameter int DW     = 16,
    parameter int TO_CYC = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           order_p,
    input  logic [B*H*DW-1:0]              dt_flat,
    input  logic [B*H*DW-1:0]              dA_flat,
    input  logic [H*DW-1:0]                D_flat,
    input  logic [B*H*P*DW-1:0]            x_flat,
    output logic                           core_start,
    input  logic                           core_done,
    output logic [B*H_TILE*DW-1:0]         dt_tile,
    output logic [B*H_TILE*DW-1:0]         dA_tile,
    output logic [H_TILE*DW-1:0]           D_tile,
    output logic [B*H_TILE*P_TILE*DW-1:0]  x_tile,
    input  logic [B*H_TILE*P_TILE*DW-1:0]  y_tile,
    output logic [$clog2(H/H_TILE):0]      tile_h_idx,
    output logic [$clog2(P/P_TILE):0]      tile_p_idx,
    output logic [15:0]                    tiles_done,
    output logic [B*H*P*DW-1:0]            y_flat,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int NHT = H / H_TILE;
    localparam int NPT = P / P_TILE;
    localparam int HIW = $clog2(NHT) + 1;
    localparam int PIW = $clog2(NPT) + 1;
    localparam int WDW = $clog2(TO_CYC + 1) + 1;

    localparam logic [HIW-1:0] H_LAST  = HIW'(NHT - 1);
    localparam logic [PIW-1:0] P_LAST  = PIW'(NPT - 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'((TO_CYC == 0) ? 0 : TO_CYC - 1);

    generate
        if (H % H_TILE != 0) begin : g_bad_h_tile
            $error("ssm_tile_sequencer: H must be a multiple of H_TILE");
        end
        if (P % P_TILE != 0) begin : g_bad_p_tile
            $error("ssm_tile_sequencer: P must be a multiple of P_TILE");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_WRITE,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [HIW-1:0]         h_idx_q, h_idx_d;
    logic [PIW-1:0]         p_idx_q, p_idx_d;
    logic                   order_q, order_d;
    logic [15:0]            tiles_q, tiles_d;
    logic [WDW-1:0]         wd_q, wd_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   core_start_q, core_start_d;
    logic [B*H*P*DW-1:0]    y_flat_q, y_flat_d;

    // Absolute head / head-dim offset of the current tile.
    int unsigned h_base;
    int unsigned p_base;
    assign h_base = 32'(h_idx_q) * 32'(H_TILE);
    assign p_base = 32'(p_idx_q) * 32'(P_TILE);

    // Input slices follow the registered indices, so they are stable from the
    // core_start cycle until the result has been written back.
    always_comb begin
        dt_tile = '0;
        dA_tile = '0;
        D_tile  = '0;
        x_tile  = '0;
        for (int hr = 0; hr < H_TILE; hr++) begin
            D_tile[hr*DW +: DW] = D_flat[(h_base + hr)*DW +: DW];
        end
        for (int b = 0; b < B; b++) begin
            for (int hr = 0; hr < H_TILE; hr++) begin
                dt_tile[(b*H_TILE + hr)*DW +: DW] = dt_flat[(b*H + h_base + hr)*DW +: DW];
                dA_tile[(b*H_TILE + hr)*DW +: DW] = dA_flat[(b*H + h_base + hr)*DW +: DW];
                for (int pr = 0; pr < P_TILE; pr++) begin
                    x_tile[((b*H_TILE + hr)*P_TILE + pr)*DW +: DW] =
                        x_flat[((b*H + h_base + hr)*P + p_base + pr)*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        h_idx_d  = h_idx_q;
        p_idx_d  = p_idx_q;
        order_d  = order_q;
        tiles_d  = tiles_q;
        wd_d     = wd_q;
        err_d    = err_q;
        y_flat_d = y_flat_q;

        // abort outranks everything, including a coincident core_done or timeout.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        h_idx_d = '0;
                        p_idx_d = '0;
                        tiles_d = '0;
                        err_d   = 1'b0;
                        order_d = order_p;
                        state_d = S_PULSE;
                    end
                end
                S_PULSE: begin
                    wd_d    = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        state_d = S_WRITE;
                    end else if ((TO_CYC != 0) && (wd_q == WD_LAST)) begin
                        state_d = S_ERR;
                    end else begin
                        wd_d = wd_q + WDW'(1);
                    end
                end
                S_WRITE: begin
                    for (int b = 0; b < B; b++) begin
                        for (int hr = 0; hr < H_TILE; hr++) begin
                            for (int pr = 0; pr < P_TILE; pr++) begin
                                y_flat_d[((b*H + h_base + hr)*P + p_base + pr)*DW +: DW] =
                                    y_tile[((b*H_TILE + hr)*P_TILE + pr)*DW +: DW];
                            end
                        end
                    end
                    tiles_d = tiles_q + 16'd1;
                    state_d = S_NEXT;
                end
                S_NEXT: begin
                    if ((h_idx_q == H_LAST) && (p_idx_q == P_LAST)) begin
                        state_d = S_DONE;
                    end else begin
                        // The outer index can only step when the inner one wraps;
                        // it never overflows here because the last tile exits above.
                        if (!order_q) begin
                            if (p_idx_q == P_LAST) begin
                                p_idx_d = '0;
                                h_idx_d = h_idx_q + HIW'(1);
                            end else begin
                                p_idx_d = p_idx_q + PIW'(1);
                            end
                        end else begin
                            if (h_idx_q == H_LAST) begin
                                h_idx_d = '0;
                                p_idx_d = p_idx_q + PIW'(1);
                            end else begin
                                h_idx_d = h_idx_q + HIW'(1);
                            end
                        end
                        state_d = S_PULSE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        core_start_d = (state_d == S_PULSE);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE) || (state_d == S_ERR);
        if (state_d == S_ERR) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            h_idx_q      <= '0;
            p_idx_q      <= '0;
            order_q      <= 1'b0;
            tiles_q      <= '0;
            wd_q         <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            core_start_q <= 1'b0;
            y_flat_q     <= '0;
        end else begin
            state_q      <= state_d;
            h_idx_q      <= h_idx_d;
            p_idx_q      <= p_idx_d;
            order_q      <= order_d;
            tiles_q      <= tiles_d;
            wd_q         <= wd_d;
            err_q        <= err_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            core_start_q <= core_start_d;
            y_flat_q     <= y_flat_d;
        end
    end

    assign core_start = core_start_q;
    assign tile_h_idx = h_idx_q;
    assign tile_p_idx = p_idx_q;
    assign tiles_done = tiles_q;
    assign y_flat     = y_flat_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
